// File: rtl/sbox_pipe_reg.sv
// sbox_pipe_reg: elastic multi-stage pipeline register for (8+d)-bit redundant
// S-Box words on LANES parallel lanes. It uses valid/ready backpressure, and
// bubbles collapse forward while the output is stalled. It also provides a
// synchronous flush and a registered occupancy count.
//
// Optional feature: define SBOX_PIPE_CLEAR_EN to zero a stage's data register
// whenever that stage loads an invalid slot (bubble, flush or empty
// predecessor). Without it, data registers keep their stale contents.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous clear of every stage
//   in_valid   upstream word available
//   in_ready   block accepts a word this cycle
//   in_data    LANES words, lane k at [k*W +: W], W = 8+d
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts this cycle
//   out_data   last-stage data
//   occupancy  number of valid stages
module sbox_pipe_reg #(
   parameter int unsigned d      = 2,
   parameter int unsigned STAGES = 3,
   parameter int unsigned LANES  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [LANES*(8+d)-1:0]          in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LANES*(8+d)-1:0]          out_data,
   output logic [$clog2(STAGES+1)-1:0]     occupancy
);

   localparam int unsigned W  = 8 + d;
   localparam int unsigned DW = LANES * W;
   localparam int unsigned OW = $clog2(STAGES + 1);

   if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
      $error("sbox_pipe_reg: STAGES must be in 1..8");
   end

   logic [STAGES-1:0] v;
   logic [DW-1:0]     data     [STAGES];
   logic [STAGES-1:0] v_nxt;
   logic [DW-1:0]     data_nxt [STAGES];
   logic [OW-1:0]     occ_nxt;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] src_v;
   logic [DW-1:0]     src_d    [STAGES];

   // Load source per stage: stage 0 from the input port, others from the predecessor.
   assign src_v[0] = in_valid;
   assign src_d[0] = in_data;
   for (genvar g = 1; g < STAGES; g++) begin : g_src
      assign src_v[g] = v[g-1];
      assign src_d[g] = data[g-1];
   end

   // Advance chain from the output side; an empty stage always advances, so bubbles collapse.
   always_comb begin : adv_chain
      adv = '0;
      adv[STAGES-1] = !v[STAGES-1] || out_ready;
      for (int i = int'(STAGES) - 2; i >= 0; i--) begin
         adv[i] = !v[i] || adv[i+1];
      end
   end

   assign in_ready  = adv[0] && !flush && !rst;
   assign out_valid = v[STAGES-1];
   assign out_data  = data[STAGES-1];

   // Next-state: flush dominates advance; held stages keep valid and data.
   always_comb begin : next_state
      v_nxt    = v;
      data_nxt = data;
      occ_nxt  = '0;
      if (flush) begin
         v_nxt = '0;
`ifdef SBOX_PIPE_CLEAR_EN
         for (int i = 0; i < int'(STAGES); i++) begin
            data_nxt[i] = '0;
         end
`endif
      end else begin
         for (int i = 0; i < int'(STAGES); i++) begin
            if (adv[i]) begin
               v_nxt[i] = src_v[i];
               if (src_v[i]) begin
                  data_nxt[i] = src_d[i];
               end
`ifdef SBOX_PIPE_CLEAR_EN
               else begin
                  data_nxt[i] = '0;
               end
`endif
            end
         end
      end
      for (int i = 0; i < int'(STAGES); i++) begin
         occ_nxt = occ_nxt + OW'(v_nxt[i]);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin : state_reg
      if (rst) begin
         v         <= '0;
         data      <= '{default: '0};
         occupancy <= '0;
      end else begin
         v         <= v_nxt;
         data      <= data_nxt;
         occupancy <= occ_nxt;
      end
   end

endmodule

// File: tb/tb_sbox_pipe_reg.sv
// Scoreboard bench for sbox_pipe_reg: single-lane (d=2, STAGES=3) and
// four-lane (d=1, STAGES=3) instances. Stimulus pushes expected words, and
// per-instance monitors pop and compare them on each output transfer.
module tb_sbox_pipe_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_data;
   logic [1:0]  occupancy;

   logic        flush_b;
   logic        in_valid_b;
   logic        in_ready_b;
   logic [35:0] in_data_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [35:0] out_data_b;
   logic [1:0]  occupancy_b;

   logic [9:0]  sb_a [$];
   logic [35:0] sb_b [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sbox_pipe_reg #(.d(2), .STAGES(3), .LANES(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .occupancy(occupancy));

   sbox_pipe_reg #(.d(1), .STAGES(3), .LANES(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .occupancy(occupancy_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor for the single-lane instance.
   always @(posedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (sb_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_word actual=%0h required=none", out_data);
         end else begin
            chk("a_out_data", 64'(out_data), 64'(sb_a.pop_front()));
         end
      end
   end

   // Monitor for the four-lane instance.
   always @(posedge clk) begin
      if (!rst && !flush_b && out_valid_b && out_ready_b) begin
         if (sb_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_word actual=%0h required=none", out_data_b);
         end else begin
            chk("b_out_data", 64'(out_data_b), 64'(sb_b.pop_front()));
         end
      end
   end

   task automatic drain_a();
      int n = 0;
      out_ready = 1'b1;
      while ((sb_a.size() != 0 || occupancy != 2'd0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("a_drain_queue", 64'(sb_a.size()), 64'(0));
      chk("a_drain_occ", 64'(occupancy), 64'(0));
   endtask

   task automatic drain_b();
      int n = 0;
      out_ready_b = 1'b1;
      while ((sb_b.size() != 0 || occupancy_b != 2'd0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b_drain_queue", 64'(sb_b.size()), 64'(0));
      chk("b_drain_occ", 64'(occupancy_b), 64'(0));
   endtask

   task automatic send_a(input logic [9:0] w);
      in_valid = 1'b1;
      in_data  = w;
      sb_a.push_back(w);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;

      // Reset state
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("empty_in_ready", 64'(in_ready), 64'(1));
      chk("empty_out_valid", 64'(out_valid), 64'(0));

      // Streaming, out_ready held high
      out_ready = 1'b1;
      @(negedge clk);
      send_a(10'h3A5);
      @(negedge clk);
      chk("stream_occ1", 64'(occupancy), 64'(1));
      send_a(10'h0FF);
      @(negedge clk);
      chk("stream_occ2", 64'(occupancy), 64'(2));
      chk("stream_latency_not_yet", 64'(out_valid), 64'(0));
      send_a(10'h200);
      @(negedge clk);
      chk("stream_occ3", 64'(occupancy), 64'(3));
      chk("stream_latency_valid", 64'(out_valid), 64'(1));
      chk("stream_first_word", 64'(out_data), 64'(10'h3A5));
      in_valid = 1'b0; in_data = '0;
      @(negedge clk);
      chk("stream_no_gap1", 64'(out_valid), 64'(1));
      @(negedge clk);
      chk("stream_no_gap2", 64'(out_valid), 64'(1));
      drain_a();

      // Backpressure: five words offered, three fit
      @(negedge clk);
      out_ready = 1'b0;
      send_a(10'h101);
      @(negedge clk);
      send_a(10'h202);
      @(negedge clk);
      send_a(10'h303);
      @(negedge clk);
      chk("bp_full_occ", 64'(occupancy), 64'(3));
      chk("bp_full_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b1; in_data = 10'h004;
      @(negedge clk);
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_data", 64'(out_data), 64'(10'h101));
      out_ready = 1'b1;
      #1;
      chk("bp_pass_ready", 64'(in_ready), 64'(1));
      sb_a.push_back(10'h004);
      @(negedge clk);
      send_a(10'h3FF);
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      drain_a();

      // Bubble collapse under stall
      @(negedge clk);
      out_ready = 1'b0;
      send_a(10'h0A1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      send_a(10'h0B2);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bubble_occ2", 64'(occupancy), 64'(2));
      chk("bubble_head", 64'(out_data), 64'(10'h0A1));
      chk("bubble_ready", 64'(in_ready), 64'(1));
      send_a(10'h0C3);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bubble_occ3", 64'(occupancy), 64'(3));
      chk("bubble_full_ready", 64'(in_ready), 64'(0));
      drain_a();

      // Flush with a full pipeline and an input offered
      @(negedge clk);
      out_ready = 1'b0;
      send_a(10'h111);
      @(negedge clk);
      send_a(10'h222);
      @(negedge clk);
      send_a(10'h333);
      @(negedge clk);
      chk("flush_pre_occ", 64'(occupancy), 64'(3));
      in_valid = 1'b1; in_data = 10'h155; flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; in_data = '0;
      sb_a.delete();
      chk("flush_occ", 64'(occupancy), 64'(0));
      chk("flush_out_valid", 64'(out_valid), 64'(0));
`ifdef SBOX_PIPE_CLEAR_EN
      chk("flush_out_data_zero", 64'(out_data), 64'(0));
`endif
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("flush_word_dropped", 64'(out_valid), 64'(0));

      // Asynchronous reset with two words in flight
      out_ready = 1'b0;
      send_a(10'h2C7);
      @(negedge clk);
      send_a(10'h138);
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      chk("rst_mid_occ_before", 64'(occupancy), 64'(2));
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
      chk("rst_mid_occ", 64'(occupancy), 64'(0));
      chk("rst_mid_out_data", 64'(out_data), 64'(0));
      chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
      sb_a.delete();
      @(negedge clk);
      rst = 1'b0;
      drain_a();

      // Multi-lane: lanes must stay in place, bit-exact
      @(negedge clk);
      in_valid_b = 1'b1;
      in_data_b  = {9'h0AA, 9'h155, 9'h000, 9'h1FF};
      sb_b.push_back(in_data_b);
      @(negedge clk);
      in_data_b  = {9'h001, 9'h100, 9'h0F0, 9'h10F};
      sb_b.push_back(in_data_b);
      @(negedge clk);
      in_valid_b = 1'b0; in_data_b = '0;
      chk("lanes_latency_not_yet", 64'(out_valid_b), 64'(0));
      @(negedge clk);
      chk("lanes_latency_valid", 64'(out_valid_b), 64'(1));
      chk("lanes_first_word", 64'(out_data_b), 64'({9'h0AA, 9'h155, 9'h000, 9'h1FF}));
      drain_b();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
